// File: rtl/hv_bundle_accumulator.sv
// Lane-wise saturating bundling accumulator for the HD datapath.
// Sums LANES signed elements per beat over a window and holds one result with per-lane sign bits.
module hv_bundle_accumulator #(
   parameter  int WIDTH     = 8,
   parameter  int ACC_WIDTH = 16,
   parameter  int LANES     = 4,
   parameter  int COUNT_MAX = 16,
   localparam int CW        = $clog2(COUNT_MAX + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*WIDTH-1:0]     in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*ACC_WIDTH-1:0] out_sum,
   output logic [LANES-1:0]           out_bits,
   output logic [CW-1:0]              out_count
);

   localparam int AW = ACC_WIDTH;
   localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [LANES*AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  out_valid_q, out_valid_d;
   logic [LANES*AW-1:0]   out_sum_q, out_sum_d;
   logic [LANES-1:0]      out_bits_q, out_bits_d;
   logic [CW-1:0]         out_count_q, out_count_d;

   logic [AW:0]           sum_s;
   logic [LANES*AW-1:0]   sat_s;
   logic [LANES-1:0]      pos_s;
   logic [CW-1:0]         count_inc_s;
   logic                  accept_s;
   logic                  close_s;

   // Per-lane widened add and clamp to the signed accumulator range.
   always_comb begin
      sum_s = '0;
      sat_s = '0;
      pos_s = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_s = {acc_q[i*AW+AW-1], acc_q[i*AW +: AW]}
               + {{(AW+1-WIDTH){in_data[i*WIDTH+WIDTH-1]}}, in_data[i*WIDTH +: WIDTH]};
         if (sum_s[AW] != sum_s[AW-1]) begin
            if (sum_s[AW]) begin
               sat_s[i*AW +: AW] = SAT_MIN;
            end else begin
               sat_s[i*AW +: AW] = SAT_MAX;
            end
         end else begin
            sat_s[i*AW +: AW] = sum_s[AW-1:0];
         end
         pos_s[i] = ~sat_s[i*AW+AW-1] & (|sat_s[i*AW +: AW]);
      end
   end

   assign in_ready    = (state_q == ST_ACCUM);
   assign accept_s    = in_valid & in_ready;
   assign count_inc_s = count_q + CW'(1);
   assign close_s     = accept_s & (in_last | (count_inc_s == CW'(COUNT_MAX)));

   // Next-state, accumulator and result-register update.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_bits_d  = out_bits_q;
      out_count_d = out_count_q;
      case (state_q)
         ST_ACCUM: begin
            if (accept_s) begin
               acc_d   = sat_s;
               count_d = count_inc_s;
               if (close_s) begin
                  state_d     = ST_HOLD;
                  out_valid_d = 1'b1;
                  out_sum_d   = sat_s;
                  out_bits_d  = pos_s;
                  out_count_d = count_inc_s;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            // Release clears the window but keeps the last result visible.
            if (out_valid_q & out_ready) begin
               state_d     = ST_ACCUM;
               acc_d       = '0;
               count_d     = '0;
               out_valid_d = 1'b0;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d     = ST_ACCUM;
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_bits_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_bits_q  <= out_bits_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_bits  = out_bits_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_hv_bundle_accumulator.sv
// Directed bench for hv_bundle_accumulator: default instance plus a narrow ACC_WIDTH=10 instance.
module tb_hv_bundle_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, in_last, out_valid, out_ready;
   logic [31:0] in_data;
   logic [63:0] out_sum;
   logic [3:0]  out_bits;
   logic [4:0]  out_count;

   logic        v10, rdy10, last10, ov10, ordy10;
   logic [31:0] data10;
   logic [39:0] sum10;
   logic [3:0]  bits10;
   logic [4:0]  cnt10;

   int passed;
   int total;

   hv_bundle_accumulator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_bits(out_bits),
      .out_count(out_count)
   );

   hv_bundle_accumulator #(.ACC_WIDTH(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .in_valid(v10), .in_ready(rdy10),
      .in_data(data10), .in_last(last10), .out_valid(ov10),
      .out_ready(ordy10), .out_sum(sum10), .out_bits(bits10),
      .out_count(cnt10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_beat(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_hold();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_sum !== 64'h0) $display("FAIL rst_out_sum: got %h want 0", out_sum); else passed++;
      total++; if (out_bits !== 4'b0000) $display("FAIL rst_out_bits: got %b want 0000", out_bits); else passed++;
      total++; if (out_count !== 5'd0) $display("FAIL rst_out_count: got %0d want 0", out_count); else passed++;
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_window();
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) send_beat({8'hF6, 8'h0A, 8'hFF, 8'h01}, 1'b0);
      total++; if (out_valid !== 1'b0) $display("FAIL full_early_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL full_early_ready: got %b want 1", in_ready); else passed++;
      send_beat({8'hF6, 8'h0A, 8'hFF, 8'h01}, 1'b0);
      total++; if (out_valid !== 1'b1) $display("FAIL full_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_sum !== {16'hFF60, 16'h00A0, 16'hFFF0, 16'h0010})
         $display("FAIL full_sum: got %h want ff6000a0fff00010", out_sum); else passed++;
      total++; if (out_bits !== 4'b0101) $display("FAIL full_bits: got %b want 0101", out_bits); else passed++;
      total++; if (out_count !== 5'd16) $display("FAIL full_count: got %0d want 16", out_count); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL full_hold_ready: got %b want 0", in_ready); else passed++;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL full_release_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL full_release_ready: got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_early_last();
      send_beat({24'h0, 8'h0A}, 1'b0);
      send_beat({24'h0, 8'h42}, 1'b0);
      send_beat({24'h0, 8'hF6}, 1'b1);
      total++; if (out_valid !== 1'b1) $display("FAIL last_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_sum !== 64'h0000_0000_0000_0042) $display("FAIL last_sum: got %h want 42", out_sum); else passed++;
      total++; if (out_bits !== 4'b0001) $display("FAIL last_bits: got %b want 0001", out_bits); else passed++;
      total++; if (out_count !== 5'd3) $display("FAIL last_count: got %0d want 3", out_count); else passed++;
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1;
      in_data  = {24'h0, 8'h05};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL bp_hold_%0d: got valid=%b ready=%b want 1/0", i, out_valid, in_ready); else passed++;
         total++; if (out_sum !== 64'h42 || out_count !== 5'd3)
            $display("FAIL bp_stable_%0d: got sum=%h count=%0d want 42/3", i, out_sum, out_count); else passed++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else passed++;
      send_beat({24'h0, 8'h05}, 1'b0);
      send_beat({24'h0, 8'h05}, 1'b1);
      total++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_sum !== 64'h0000_0000_0000_000A) $display("FAIL bp_next_sum: got %h want a", out_sum); else passed++;
      total++; if (out_count !== 5'd2) $display("FAIL bp_next_count: got %0d want 2", out_count); else passed++;
      release_hold();
   endtask

   task automatic test_saturation();
      ordy10 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v10    = 1'b1;
         data10 = {16'h0, 8'h80, 8'h7F};
         last10 = (i == 4);
         @(posedge clk);
         #1;
      end
      v10 = 1'b0;
      last10 = 1'b0;
      total++; if (ov10 !== 1'b1) $display("FAIL sat_valid: got %b want 1", ov10); else passed++;
      total++; if (sum10 !== {10'h000, 10'h000, 10'h200, 10'h1FF})
         $display("FAIL sat_sum: got %h want 00000801ff", sum10); else passed++;
      total++; if (bits10 !== 4'b0001) $display("FAIL sat_bits: got %b want 0001", bits10); else passed++;
      total++; if (cnt10 !== 5'd5) $display("FAIL sat_count: got %0d want 5", cnt10); else passed++;
   endtask

   task automatic test_tie();
      send_beat({16'h0, 8'hFD, 8'h03}, 1'b0);
      send_beat({16'h0, 8'h03, 8'hFD}, 1'b1);
      total++; if (out_sum !== 64'h0) $display("FAIL tie_sum: got %h want 0", out_sum); else passed++;
      total++; if (out_bits !== 4'b0000) $display("FAIL tie_bits: got %b want 0000", out_bits); else passed++;
      total++; if (out_count !== 5'd2) $display("FAIL tie_count: got %0d want 2", out_count); else passed++;
      release_hold();
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) send_beat({24'h0, 8'h07}, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_count !== 5'd0) $display("FAIL mrst_count: got %0d want 0", out_count); else passed++;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mrst_flags: got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
      total++; if (ov10 !== 1'b0 || sum10 !== 40'h0)
         $display("FAIL mrst_dut10: got valid=%b sum=%h want 0/0", ov10, sum10); else passed++;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) send_beat({24'h0, 8'h01}, 1'b0);
      total++; if (out_valid !== 1'b0) $display("FAIL mrst_no_carry: got valid=%b want 0", out_valid); else passed++;
      send_beat({24'h0, 8'h01}, 1'b0);
      total++; if (out_valid !== 1'b1) $display("FAIL mrst_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_sum !== 64'h0000_0000_0000_0010) $display("FAIL mrst_sum: got %h want 10", out_sum); else passed++;
      total++; if (out_count !== 5'd16) $display("FAIL mrst_win_count: got %0d want 16", out_count); else passed++;
      release_hold();
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      v10       = 1'b0;
      data10    = 32'h0;
      last10    = 1'b0;
      ordy10    = 1'b0;
      test_reset();
      test_full_window();
      test_early_last();
      test_backpressure();
      test_saturation();
      test_tie();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hv_bundle_accumulator.md
Name: hv_bundle_accumulator

Overview:
- Streaming bundling stage that sits directly downstream of the N-bit element adder in the HD datapath.
- Consumes LANES signed WIDTH-bit element sums per beat and accumulates them lane-wise into saturating ACC_WIDTH-bit accumulators over a sample window.
- At the end of the window it presents the bundled sums plus a per-lane majority (sign) bit to the next stage.
- Valid/ready handshake on both sides; one result is held at a time.

Parameters:
- WIDTH, 8, signed width of each input element (matches adder output width).
- ACC_WIDTH, 16, signed width of each lane accumulator; must be >= WIDTH.
- LANES, 4, number of parallel elements per beat.
- COUNT_MAX, 16, samples per bundle window; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH], two's complement.
- in_last  in  1  qualifies the beat as the final one of the window (early close).
- out_valid  out  1  bundled result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  LANES*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH], signed.
- out_bits  out  LANES  per-lane majority bit.
- out_count  out  $clog2(COUNT_MAX+1)  number of beats in the reported window.

Behaviour:
- One clock; rst_n is asynchronous and active-low. Assertion immediately forces:
  - state = ACCUM, all accumulators = 0, count = 0;
  - out_valid = 0, out_sum = 0, out_bits = 0, out_count = 0.
- in_ready = (state == ACCUM), combinational from state. It is 1 while in reset and after reset.
- States:
  - ACCUM: accepting beats.
  - HOLD: result presented.
- Accept condition: in_valid & in_ready at a rising edge. On accept:
  - acc[i] <= sat(acc[i] + sext(in_data lane i));
  - count <= count + 1.
- Saturation: the result clamps to [-(2^(ACC_WIDTH-1)), 2^(ACC_WIDTH-1)-1]. Compute at ACC_WIDTH+1 bits and clamp; there is no wrap-around.
- ACCUM -> HOLD on an accepted beat when in_last = 1 or count+1 == COUNT_MAX. Otherwise stay in ACCUM.
- Output timing:
  - out_valid is registered; it rises the cycle after the closing beat.
  - out_sum and out_count are registered with final values on the same edge.
  - Latency from last accept to out_valid = 1 cycle.
- out_bits[i] = 1 iff out_sum lane i > 0. A tie (sum = 0) or a negative sum gives 0.
- HOLD:
  - out_valid, out_sum, out_bits and out_count stay stable until out_valid & out_ready.
  - in_ready = 0, so no beats are accepted and in_valid is ignored.
- HOLD -> ACCUM on out_valid & out_ready. On that edge:
  - accumulators and count clear;
  - out_valid clears;
  - out_sum, out_bits and out_count hold their last values (don't-care while out_valid = 0).
  - in_ready = 1 in the following cycle. No simultaneous accept/release is possible.
- in_last with COUNT_MAX = 1, or in_last on the COUNT_MAX-th beat, closes the window once, identically.
- in_last while in_valid = 0 has no effect.
- Reset mid-window discards the partial accumulation. Counting restarts from 0 after release.

Test Plan:
1. Default params; 16 beats of lanes (0..3) = (1, -1, 10, -10), in_last = 0, out_ready = 1 -> one cycle after the 16th accept: out_valid = 1, out_sum = (16, -16, 160, -160), out_bits = 4'b0101, out_count = 16; in_ready = 0 during HOLD.
2. Lane 0 beats 10, 66, -10 (other lanes 0), in_last on the 3rd -> out_sum lane 0 = 66, lanes 1-3 = 0, out_bits = 4'b0001, out_count = 3.
3. After scenario 2, hold out_ready = 0 for 5 cycles while in_valid = 1 with data 5 -> out_valid and outputs stable, no beats accepted. Raise out_ready -> out_valid drops the next cycle and in_ready = 1. The next window of 2 beats (5, in_last) gives lane 0 = 10, out_count = 2.
4. ACC_WIDTH = 10; 5 beats of 127 on lane 0 and -128 on lane 1, in_last on the 5th -> lane 0 = 511, lane 1 = -512 (saturated, no wrap).
5. Beats (3, -3) then (-3, 3) on lanes 0/1, in_last on the 2nd -> out_sum = 0 on both lanes, out_bits = 4'b0000 (tie -> 0).
6. Accept 5 beats of lane 0 = 7, then pulse rst_n low mid-cycle -> outputs and counters clear asynchronously. Release and send 16 beats of 1 -> lane 0 = 16, out_count = 16; no carry-over from before reset.
